// File: rtl/mux8x1_rr_if.sv
// rtl/mux8x1_rr_if.sv - lane-side and result-side handshake bundle for mux8x1_rr
interface mux8x1_rr_if #(
    parameter int WIDTH = 1
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   result;
    logic [2:0]         sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, result, sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, result, sel, out_valid
    );
endinterface

// File: rtl/mux8x1_rr.sv
// rtl/mux8x1_rr.sv - 8-lane to 1-lane round-robin mux with registered result and lane index
// Optional fixed-select mode enabled by defining MUX8X1_FORCE_SEL_EN.
module mux8x1_rr #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic rst,
`ifdef MUX8X1_FORCE_SEL_EN
    input logic       force_en,
    input logic [2:0] force_sel,
`endif
    mux8x1_rr_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             adv;
    logic [7:0]       eligible;
    logic             found;
    logic [2:0]       gnt_idx;
    logic [2:0]       idx;
    logic             grant;
    logic [7:0]       in_ready_c;

    always_comb begin
        adv      = (state_q == EMPTY) || bus.out_ready;
        eligible = bus.in_valid;
`ifdef MUX8X1_FORCE_SEL_EN
        if (force_en) begin
            eligible = bus.in_valid & (8'b1 << force_sel);
        end
`endif
        // First eligible lane scanning upward from ptr, wrapping 7->0.
        found   = 1'b0;
        gnt_idx = 3'd0;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end

        grant      = adv && found && !rst;
        in_ready_c = grant ? (8'b1 << gnt_idx) : 8'b0;

        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        result_d = result_q;
        if (grant) begin
            state_d  = FULL;
            sel_d    = gnt_idx;
            result_d = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
`ifdef MUX8X1_FORCE_SEL_EN
            if (!force_en) begin
                ptr_d = gnt_idx + 3'd1;
            end
`else
            ptr_d = gnt_idx + 3'd1;
`endif
        end else if (adv) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= 3'd0;
            sel_q    <= 3'd0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.result    = result_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux8x1_rr.sv
// tb/tb_mux8x1_rr.sv - directed self-checking bench for mux8x1_rr
module tb_mux8x1_rr;
    localparam int WIDTH = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] pat;

`ifdef MUX8X1_FORCE_SEL_EN
    logic       force_en  = 1'b0;
    logic [2:0] force_sel = 3'd0;
`endif

    mux8x1_rr_if #(.WIDTH(WIDTH)) ifc ();

    mux8x1_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX8X1_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .bus       (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat           = 8'hA5;
        ifc.in_data   = pat;
        ifc.in_valid  = 8'hFF;
        ifc.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_result", 32'(ifc.result), 32'd0);
        chk("rst_sel", 32'(ifc.sel), 32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);

        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_in_ready", 32'(ifc.in_ready), 32'(8'b1 << (k % 8)));
            tick();
            chk("rr_sel", 32'(ifc.sel), 32'(k % 8));
            chk("rr_result", 32'(ifc.result), 32'(pat[k % 8]));
            chk("rr_out_valid", 32'(ifc.out_valid), 32'd1);
        end

        // stall while holding lane 0's word; ptr=1
        ifc.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
            tick();
            chk("stall_sel", 32'(ifc.sel), 32'd0);
            chk("stall_result", 32'(ifc.result), 32'd1);
            chk("stall_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        ifc.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(ifc.in_ready), 32'h02);
        tick();
        chk("unstall_sel", 32'(ifc.sel), 32'd1);
        chk("unstall_result", 32'(ifc.result), 32'd0);

        // drain with no valid lanes; ptr stays 2
        ifc.in_valid = 8'h00;
        #1;
        chk("drain_in_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        chk("drain_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("drain_sel_hold", 32'(ifc.sel), 32'd1);
        chk("drain_result_hold", 32'(ifc.result), 32'd0);
        tick();
        chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);
        ifc.in_valid = 8'hFF;
        #1;
        chk("ptr_kept_in_ready", 32'(ifc.in_ready), 32'h04);
        tick();
        chk("ptr_kept_sel", 32'(ifc.sel), 32'd2);
        chk("ptr_kept_result", 32'(ifc.result), 32'd1);

        // ptr=3: grant lane 4 alone to move ptr to 5
        ifc.in_valid = 8'h10;
        #1;
        chk("lane4_in_ready", 32'(ifc.in_ready), 32'h10);
        tick();
        chk("lane4_sel", 32'(ifc.sel), 32'd4);
        ifc.in_valid = 8'h90;
        #1;
        chk("wrap_in_ready_a", 32'(ifc.in_ready), 32'h80);
        tick();
        chk("wrap_sel_a", 32'(ifc.sel), 32'd7);
        chk("wrap_result_a", 32'(ifc.result), 32'd1);
        #1;
        chk("wrap_in_ready_b", 32'(ifc.in_ready), 32'h10);
        tick();
        chk("wrap_sel_b", 32'(ifc.sel), 32'd4);
        chk("wrap_result_b", 32'(ifc.result), 32'd0);

        // ptr=5: load lane 5 then reset mid-stream
        ifc.in_valid = 8'hFF;
        tick();
        chk("pre_rst_sel", 32'(ifc.sel), 32'd5);
        chk("pre_rst_out_valid", 32'(ifc.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", 32'(ifc.result), 32'd0);
        chk("mid_rst_sel", 32'(ifc.sel), 32'd0);
        chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ifc.in_ready), 32'h01);
        tick();
        chk("post_rst_sel", 32'(ifc.sel), 32'd0);

`ifdef MUX8X1_FORCE_SEL_EN
        // ptr=1 before forcing; forced grants leave it alone
        force_en  = 1'b1;
        force_sel = 3'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("force_in_ready", 32'(ifc.in_ready), 32'h08);
            tick();
            chk("force_sel", 32'(ifc.sel), 32'd3);
        end
        force_en = 1'b0;
        #1;
        chk("unforce_in_ready", 32'(ifc.in_ready), 32'h02);
        tick();
        chk("unforce_sel", 32'(ifc.sel), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
